// File: rtl/wf_fetch_pkg.sv
// Shared defaults and per-slot state type for the wavefront fetch scheduler.
package wf_fetch_pkg;

  localparam int DEF_NUM_WF      = 40;
  localparam int DEF_WFID_W      = 6;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_FETCH_BYTES = 4;

  typedef struct packed {
    logic                valid;
    logic                outstanding;
    logic [DEF_PC_W-1:0] pc;
  } wf_slot_t;

endpackage

// File: rtl/wf_fetch_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from last_grant+1, wrapping at N-1.
module rr_arbiter #(
  parameter int N    = 40,
  parameter int ID_W = 6
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  // First requester after last_grant in circular order wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            hit;
    sum         = '0;
    idx         = '0;
    hit         = 1'b0;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= N; k++) begin
      sum         = {1'b0, last_grant} + (ID_W+1)'(k);
      idx         = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N)) : ID_W'(sum);
      hit         = ~grant_valid & req[idx];
      grant_id    = hit ? idx : grant_id;
      grant_valid = grant_valid | req[idx];
    end
  end

endmodule

// File: rtl/wf_fetch_sched.sv
// Wavefront instruction-fetch scheduler; PC_W must match the package PC width.
// Optional fetch_count output is built when WF_FETCH_PERF_CNT_EN is defined.
module wf_fetch_sched
  import wf_fetch_pkg::*;
#(
  parameter int NUM_WF      = DEF_NUM_WF,
  parameter int WFID_W      = DEF_WFID_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int FETCH_BYTES = DEF_FETCH_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wf_alloc_en,
  input  logic [WFID_W-1:0] wf_alloc_id,
  input  logic [PC_W-1:0]   wf_alloc_pc,
  input  logic              wf_done_en,
  input  logic [WFID_W-1:0] wf_done_id,
  input  logic [NUM_WF-1:0] stop_fetch,
  input  logic              branch_en,
  input  logic [WFID_W-1:0] branch_wfid,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_pc,
  input  logic              buff_rdy,
  output logic              buff_rd_en,
  output logic [PC_W-1:0]   buff_addr,
  output logic [WFID_W-1:0] buff_wfid,
  input  logic              buff_ack,
  input  logic [WFID_W-1:0] buff_ack_wfid,
  output logic [NUM_WF-1:0] active_mask
`ifdef WF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  wf_slot_t          slot_r [NUM_WF];
  wf_slot_t          slot_s [NUM_WF];
  logic [WFID_W-1:0] last_grant_r;

  logic [NUM_WF-1:0] elig_s;
  logic [NUM_WF-1:0] alloc_hit_s;
  logic [NUM_WF-1:0] done_hit_s;
  logic [NUM_WF-1:0] branch_hit_s;
  logic [NUM_WF-1:0] ack_hit_s;
  logic [NUM_WF-1:0] issue_hit_s;
  logic              grant_valid_s;
  logic [WFID_W-1:0] grant_id_s;
  logic              issue_s;

  assign issue_s = buff_rdy & grant_valid_s;

  // Per-slot event decode; out-of-range ids never match any slot.
  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      alloc_hit_s[i]  = wf_alloc_en & (wf_alloc_id == WFID_W'(i));
      done_hit_s[i]   = wf_done_en & (wf_done_id == WFID_W'(i));
      branch_hit_s[i] = branch_en & (branch_wfid == WFID_W'(i));
      ack_hit_s[i]    = buff_ack & (buff_ack_wfid == WFID_W'(i));
      issue_hit_s[i]  = issue_s & (grant_id_s == WFID_W'(i));
      elig_s[i]       = slot_r[i].valid & ~slot_r[i].outstanding &
                        ~stop_fetch[i] & ~branch_hit_s[i];
      active_mask[i]  = slot_r[i].valid;
    end
  end

  rr_arbiter #(
    .N    (NUM_WF),
    .ID_W (WFID_W)
  ) u_arb (
    .req         (elig_s),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Slot next state; priority alloc > done > (issue | branch + ack).
  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      slot_s[i] = slot_r[i];
      if (alloc_hit_s[i]) begin
        slot_s[i].valid       = 1'b1;
        slot_s[i].outstanding = 1'b0;
        slot_s[i].pc          = wf_alloc_pc;
      end else if (done_hit_s[i]) begin
        slot_s[i].valid       = 1'b0;
        slot_s[i].outstanding = 1'b0;
      end else if (issue_hit_s[i]) begin
        slot_s[i].outstanding = 1'b1;
        slot_s[i].pc          = slot_r[i].pc + PC_W'(FETCH_BYTES);
      end else begin
        // An issued slot is never branching or outstanding, so these only apply otherwise.
        if (branch_hit_s[i] & slot_r[i].valid & branch_taken) begin
          slot_s[i].pc = branch_pc;
        end else begin
          slot_s[i].pc = slot_r[i].pc;
        end
        if (ack_hit_s[i] & slot_r[i].outstanding) begin
          slot_s[i].outstanding = 1'b0;
        end else begin
          slot_s[i].outstanding = slot_r[i].outstanding;
        end
      end
    end
  end

  // Slot state, arbitration pointer and registered fetch request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        slot_r[i] <= '0;
      end
      last_grant_r <= WFID_W'(NUM_WF - 1);
      buff_rd_en   <= 1'b0;
      buff_addr    <= '0;
      buff_wfid    <= '0;
    end else begin
      slot_r     <= slot_s;
      buff_rd_en <= issue_s;
      if (issue_s) begin
        last_grant_r <= grant_id_s;
        buff_addr    <= slot_r[grant_id_s].pc;
        buff_wfid    <= grant_id_s;
      end else begin
        last_grant_r <= last_grant_r;
        buff_addr    <= buff_addr;
        buff_wfid    <= buff_wfid;
      end
    end
  end

`ifdef WF_FETCH_PERF_CNT_EN
  // Free-running count of issued fetch requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (issue_s) begin
      fetch_count <= fetch_count + 32'd1;
    end else begin
      fetch_count <= fetch_count;
    end
  end
`endif

endmodule

// File: tb/tb_wf_fetch_sched.sv
// Self-checking bench for wf_fetch_sched: vector table, directed corner cases, random vs model.
module tb_wf_fetch_sched;
  localparam int N = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wf_alloc_en, wf_done_en, branch_en, branch_taken, buff_rdy, buff_ack;
  logic [5:0]  wf_alloc_id, wf_done_id, branch_wfid, buff_ack_wfid;
  logic [31:0] wf_alloc_pc, branch_pc;
  logic [N-1:0] stop_fetch;
  logic        buff_rd_en;
  logic [31:0] buff_addr;
  logic [5:0]  buff_wfid;
  logic [N-1:0] active_mask;
`ifdef WF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int tests = 0;
  int fails = 0;

  wf_fetch_sched dut (
    .clk(clk), .rst(rst),
    .wf_alloc_en(wf_alloc_en), .wf_alloc_id(wf_alloc_id), .wf_alloc_pc(wf_alloc_pc),
    .wf_done_en(wf_done_en), .wf_done_id(wf_done_id),
    .stop_fetch(stop_fetch),
    .branch_en(branch_en), .branch_wfid(branch_wfid), .branch_taken(branch_taken),
    .branch_pc(branch_pc),
    .buff_rdy(buff_rdy), .buff_rd_en(buff_rd_en), .buff_addr(buff_addr),
    .buff_wfid(buff_wfid), .buff_ack(buff_ack), .buff_ack_wfid(buff_ack_wfid),
    .active_mask(active_mask)
`ifdef WF_FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        alloc_en;
    logic [5:0]  alloc_id;
    logic [31:0] alloc_pc;
    logic        ack_en;
    logic [5:0]  ack_id;
    logic        exp_rd;
    logic [5:0]  exp_wfid;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl [8];

  // Behavioural reference state
  bit          mv [N];
  bit          mo [N];
  logic [31:0] mpc [N];
  int          mlast;
  bit          e_rd;
  logic [31:0] e_addr;
  logic [5:0]  e_wfid;
  logic [31:0] e_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wf_alloc_en = 1'b0; wf_alloc_id = 6'd0; wf_alloc_pc = 32'd0;
    wf_done_en = 1'b0; wf_done_id = 6'd0;
    branch_en = 1'b0; branch_wfid = 6'd0; branch_taken = 1'b0; branch_pc = 32'd0;
    buff_rdy = 1'b1; buff_ack = 1'b0; buff_ack_wfid = 6'd0;
    stop_fetch = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; mo[i] = 1'b0; mpc[i] = 32'd0;
    end
    mlast = N - 1; e_rd = 1'b0; e_addr = 32'd0; e_wfid = 6'd0; e_cnt = 32'd0;
  endtask

  // Apply the rules to the current inputs: predict the next outputs and advance the model.
  task automatic model_step();
    bit          nv [N];
    bit          no [N];
    logic [31:0] npc [N];
    int          g;
    g = -1;
    if (buff_rdy) begin
      for (int k = 1; k <= N && g < 0; k++) begin
        int s;
        s = (mlast + k) % N;
        if (mv[s] && !mo[s] && !stop_fetch[s] && !(branch_en && int'(branch_wfid) == s)) g = s;
      end
    end
    e_rd = (g >= 0);
    if (g >= 0) begin
      e_addr = mpc[g]; e_wfid = 6'(g); e_cnt = e_cnt + 32'd1;
    end
    for (int s = 0; s < N; s++) begin
      nv[s] = mv[s]; no[s] = mo[s]; npc[s] = mpc[s];
      if (wf_alloc_en && int'(wf_alloc_id) == s) begin
        nv[s] = 1'b1; no[s] = 1'b0; npc[s] = wf_alloc_pc;
      end else if (wf_done_en && int'(wf_done_id) == s) begin
        nv[s] = 1'b0; no[s] = 1'b0;
      end else if (g == s) begin
        no[s] = 1'b1; npc[s] = mpc[s] + 32'd4;
      end else begin
        if (branch_en && int'(branch_wfid) == s && mv[s] && branch_taken) npc[s] = branch_pc;
        if (buff_ack && int'(buff_ack_wfid) == s && mo[s]) no[s] = 1'b0;
      end
    end
    if (g >= 0) mlast = g;
    for (int s = 0; s < N; s++) begin
      mv[s] = nv[s]; mo[s] = no[s]; mpc[s] = npc[s];
    end
  endtask

  function automatic logic [5:0] rand_id();
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
    else if ($urandom_range(0, 1) == 0) return 6'($urandom_range(36, 39));
    else return 6'($urandom_range(0, 7));
  endfunction

  logic [N-1:0] exp_mask;

  initial begin
    idle();
    // Reset state checks while rst is held
    #2;
    chk("reset_rd_en", 64'(buff_rd_en), 64'd0);
    chk("reset_addr", 64'(buff_addr), 64'd0);
    chk("reset_wfid", 64'(buff_wfid), 64'd0);
    chk("reset_mask", 64'(active_mask), 64'd0);

    // Basic issue and round-robin wrap 0,1,39,0
    tbl[0] = '{1'b1, 6'd0,  32'h000, 1'b0, 6'd0,  1'b0, 6'd0,  32'h000};
    tbl[1] = '{1'b1, 6'd1,  32'h100, 1'b0, 6'd0,  1'b1, 6'd0,  32'h000};
    tbl[2] = '{1'b1, 6'd39, 32'h200, 1'b0, 6'd0,  1'b1, 6'd1,  32'h100};
    tbl[3] = '{1'b0, 6'd0,  32'h000, 1'b1, 6'd0,  1'b1, 6'd39, 32'h200};
    tbl[4] = '{1'b0, 6'd0,  32'h000, 1'b1, 6'd1,  1'b1, 6'd0,  32'h004};
    tbl[5] = '{1'b0, 6'd0,  32'h000, 1'b1, 6'd39, 1'b1, 6'd1,  32'h104};
    tbl[6] = '{1'b0, 6'd0,  32'h000, 1'b0, 6'd0,  1'b1, 6'd39, 32'h204};
    tbl[7] = '{1'b0, 6'd0,  32'h000, 1'b1, 6'd0,  1'b0, 6'd0,  32'h000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      wf_alloc_en = tbl[i].alloc_en; wf_alloc_id = tbl[i].alloc_id; wf_alloc_pc = tbl[i].alloc_pc;
      buff_ack = tbl[i].ack_en; buff_ack_wfid = tbl[i].ack_id;
      tick();
      chk($sformatf("vec%0d_rd_en", i), 64'(buff_rd_en), 64'(tbl[i].exp_rd));
      if (tbl[i].exp_rd) begin
        chk($sformatf("vec%0d_wfid", i), 64'(buff_wfid), 64'(tbl[i].exp_wfid));
        chk($sformatf("vec%0d_addr", i), 64'(buff_addr), 64'(tbl[i].exp_addr));
      end
    end
    idle();
    buff_rdy = 1'b0;
    buff_ack = 1'b1; buff_ack_wfid = 6'd1;
    tick();
    idle();
    buff_rdy = 1'b0;
    tick();
    chk("rdy_low_no_issue", 64'(buff_rd_en), 64'd0);

    // Taken branch while outstanding redirects the next fetch
    do_reset();
    wf_alloc_en = 1'b1; wf_alloc_id = 6'd0; wf_alloc_pc = 32'h10;
    tick(); idle();
    tick();
    chk("br_first_addr", 64'(buff_addr), 64'h10);
    branch_en = 1'b1; branch_wfid = 6'd0; branch_taken = 1'b1; branch_pc = 32'h30;
    tick(); idle();
    chk("br_outstanding_rd", 64'(buff_rd_en), 64'd0);
    buff_ack = 1'b1; buff_ack_wfid = 6'd0;
    tick(); idle();
    chk("br_ack_no_bypass", 64'(buff_rd_en), 64'd0);
    tick();
    chk("br_target_rd", 64'(buff_rd_en), 64'd1);
    chk("br_target_addr", 64'(buff_addr), 64'h30);

    // stop_fetch inhibits, release issues one cycle later
    do_reset();
    stop_fetch[0] = 1'b1;
    wf_alloc_en = 1'b1; wf_alloc_id = 6'd0; wf_alloc_pc = 32'h40;
    tick();
    wf_alloc_en = 1'b0;
    tick();
    chk("stop_rd_a", 64'(buff_rd_en), 64'd0);
    tick();
    chk("stop_rd_b", 64'(buff_rd_en), 64'd0);
    stop_fetch[0] = 1'b0;
    tick();
    chk("stop_release_rd", 64'(buff_rd_en), 64'd1);
    chk("stop_release_addr", 64'(buff_addr), 64'h40);

    // Same-cycle done+alloc on slot 1, then a stale ack
    do_reset();
    wf_alloc_en = 1'b1; wf_alloc_id = 6'd1; wf_alloc_pc = 32'h8;
    tick(); idle();
    tick();
    chk("realloc_first_addr", 64'(buff_addr), 64'h8);
    wf_done_en = 1'b1; wf_done_id = 6'd1;
    wf_alloc_en = 1'b1; wf_alloc_id = 6'd1; wf_alloc_pc = 32'h18;
    tick(); idle();
    chk("realloc_valid", 64'(active_mask[1]), 64'd1);
    buff_ack = 1'b1; buff_ack_wfid = 6'd1;
    tick(); idle();
    chk("realloc_rd", 64'(buff_rd_en), 64'd1);
    chk("realloc_addr", 64'(buff_addr), 64'h18);
    tick();
    chk("stale_ack_ignored_a", 64'(buff_rd_en), 64'd0);
    tick();
    chk("stale_ack_ignored_b", 64'(buff_rd_en), 64'd0);

    // Out-of-range id is ignored
    wf_alloc_en = 1'b1; wf_alloc_id = 6'd45; wf_alloc_pc = 32'h500;
    tick(); idle();
    chk("oor_alloc_mask", 64'(active_mask), 64'h2);

    // Asynchronous reset with three fetches in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wf_alloc_en = 1'b1; wf_alloc_id = 6'(i); wf_alloc_pc = 32'h80 + 32'(i * 16);
      tick();
    end
    idle();
    tick();
    chk("pre_rst_addr", 64'(buff_addr), 64'ha0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_rd", 64'(buff_rd_en), 64'd0);
    chk("async_rst_addr", 64'(buff_addr), 64'd0);
    chk("async_rst_wfid", 64'(buff_wfid), 64'd0);
    chk("async_rst_mask", 64'(active_mask), 64'd0);
`ifdef WF_FETCH_PERF_CNT_EN
    chk("async_rst_count", 64'(fetch_count), 64'd0);
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      buff_ack = 1'b1; buff_ack_wfid = 6'(i);
      tick();
      chk("post_rst_ack_rd", 64'(buff_rd_en), 64'd0);
    end
    idle();
    chk("post_rst_mask", 64'(active_mask), 64'd0);

    // Randomised run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      buff_rdy = ($urandom_range(0, 3) != 0);
      wf_alloc_en = ($urandom_range(0, 9) == 0);
      wf_alloc_id = rand_id(); wf_alloc_pc = $urandom;
      wf_done_en = ($urandom_range(0, 19) == 0);
      wf_done_id = rand_id();
      branch_en = ($urandom_range(0, 6) == 0);
      branch_wfid = rand_id(); branch_taken = $urandom_range(0, 1) == 1; branch_pc = $urandom;
      buff_ack = ($urandom_range(0, 4) < 2);
      buff_ack_wfid = rand_id();
      if ($urandom_range(0, 2) != 0) begin
        int off;
        off = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) begin
          if (mo[(off + k) % N]) begin
            buff_ack_wfid = 6'((off + k) % N);
            break;
          end
        end
      end
      for (int i = 0; i < N; i++) stop_fetch[i] = ($urandom_range(0, 9) == 0);
      model_step();
      tick();
      chk("rnd_rd_en", 64'(buff_rd_en), 64'(e_rd));
      if (e_rd) begin
        chk("rnd_addr", 64'(buff_addr), 64'(e_addr));
        chk("rnd_wfid", 64'(buff_wfid), 64'(e_wfid));
      end
      for (int i = 0; i < N; i++) exp_mask[i] = mv[i];
      chk("rnd_mask", 64'(active_mask), 64'(exp_mask));
`ifdef WF_FETCH_PERF_CNT_EN
      chk("rnd_count", 64'(fetch_count), 64'(e_cnt));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wf_fetch_sched.md
WF_FETCH_SCHED -- requirements
Module: wf_fetch_sched

Interface
- REQ-001 Parameters (name, default, meaning) SHALL be:
  - NUM_WF, 40, wavefront slots.
  - WFID_W, 6, slot-id width (SHALL satisfy 2^WFID_W >= NUM_WF).
  - PC_W, 32, PC width.
  - FETCH_BYTES, 4, PC increment per fetch.
- REQ-002 Ports (name, direction, width, meaning) SHALL be:
  - clk  in  1  single clock.
  - rst  in  1  reset; asynchronous, active-high.
  - wf_alloc_en  in  1  load a new wavefront.
  - wf_alloc_id  in  WFID_W  slot to load.
  - wf_alloc_pc  in  PC_W  start PC.
  - wf_done_en  in  1  retire a slot.
  - wf_done_id  in  WFID_W  slot to retire.
  - stop_fetch  in  NUM_WF  per-slot fetch inhibit.
  - branch_en  in  1  branch resolved.
  - branch_wfid  in  WFID_W  branching slot.
  - branch_taken  in  1  branch taken.
  - branch_pc  in  PC_W  branch target.
  - buff_rdy  in  1  instruction buffer accepts a request.
  - buff_rd_en  out  1  fetch request strobe.
  - buff_addr  out  PC_W  fetch address.
  - buff_wfid  out  WFID_W  requesting slot.
  - buff_ack  in  1  fetch data returned.
  - buff_ack_wfid  in  WFID_W  slot whose fetch returned.
  - active_mask  out  NUM_WF  valid slots.

Function
- REQ-003 Per-slot state SHALL be: valid, outstanding, PC[PC_W].
- REQ-004 Eligibility: valid & ~outstanding & ~stop_fetch[i] & ~(branch_en & branch_wfid==i).
- REQ-005 Selection SHALL be round-robin: start at slot (last_grant+1) mod NUM_WF; wrap from NUM_WF-1 to 0.
- REQ-006 Issue SHALL happen only when buff_rdy=1 and at least one slot is eligible. It is a registered one-cycle buff_rd_en pulse, with buff_addr = PC of the granted slot and buff_wfid = granted id.
- REQ-007 Issue SHALL, on the same edge:
  - set outstanding for the granted slot;
  - advance its PC by FETCH_BYTES, modulo 2^PC_W;
  - update last_grant.
- REQ-008 Latency: eligibility to buff_rd_en SHALL be exactly 1 clk.
- REQ-009 buff_ack SHALL clear outstanding[buff_ack_wfid]. The slot becomes eligible the following cycle; there is no same-cycle bypass.
- REQ-010 An ack to a slot that is not outstanding SHALL be ignored.
- REQ-011 Taken branch SHALL load PC = branch_pc. Not-taken SHALL leave PC unchanged. Branches to invalid slots SHALL be ignored.
- REQ-012 wf_alloc_en SHALL set valid, clear outstanding and load PC = wf_alloc_pc.
- REQ-013 wf_done_en SHALL clear valid and outstanding; any later ack for that slot falls under REQ-010.
- REQ-014 Simultaneous events on the same slot SHALL resolve as:
  - alloc beats done;
  - alloc beats branch;
  - done beats branch and ack.
- REQ-015 Simultaneous events on different slots SHALL all take effect in the same cycle.
- REQ-016 Ids >= NUM_WF on any input SHALL be ignored.
- REQ-017 buff_rd_en SHALL be 0 whenever no slot is eligible or buff_rdy=0.

Reset
- REQ-018 On rst=1, asynchronously:
  - valid, outstanding = 0;
  - PC = 0;
  - last_grant = NUM_WF-1;
  - buff_rd_en = 0, buff_addr = 0, buff_wfid = 0;
  - active_mask = 0.
- REQ-019 Reset asserted mid-operation SHALL discard all outstanding fetches. Acks arriving after reset falls SHALL be ignored per REQ-010.

Configuration
- REQ-020 Macro WF_FETCH_PERF_CNT_EN:
  - Defined: adds output fetch_count[31:0]. It increments by 1 per buff_rd_en pulse, wraps at 2^32, and resets to 0.
  - Undefined: the port and its counter are absent; all other behaviour is unchanged.

Structure
- REQ-021 A shared package wf_fetch_pkg SHALL hold:
  - the default NUM_WF, WFID_W, PC_W and FETCH_BYTES constants;
  - the per-slot state struct typedef.
- REQ-022 Round-robin selection SHALL be a sub-module, rr_arbiter, parametrised by N, with inputs req[N] and last_grant and outputs grant_valid and grant_id.

Verification
- REQ-023 Alloc slot 0 at PC 0x0 with buff_rdy=1 -> next cycle buff_rd_en=1, buff_addr=0x0, buff_wfid=0; slot PC becomes 0x4.
- REQ-024 Alloc slots 0, 1 and 39; ack each fetch 2 cycles later -> grant order 0, 1, 39, 0 (wrap-around).
- REQ-025 Slot 0 outstanding, taken branch to 0x30, then ack -> next fetch buff_addr=0x30.
- REQ-026 stop_fetch[0]=1 with slot 0 valid -> no request for slot 0; clearing stop_fetch[0] -> request at the following cycle.
- REQ-027 wf_done_en and wf_alloc_en on slot 1 in the same cycle with PC 0x18 -> slot 1 valid, next buff_addr=0x18; a stale ack on slot 1 causes no change.
- REQ-028 Assert rst mid-run with 3 outstanding fetches -> all outputs 0 immediately (asynchronous); active_mask=0; fetch_count=0 when WF_FETCH_PERF_CNT_EN is defined.
